// File: rtl/serv_debug_host.sv
// Host-side debug entry for SERV: requests debug mode, deserializes the PC
// the core streams out LSB-first, and holds it until the debugger resumes.
module serv_debug_host #(
    parameter int TIMEOUT_W      = 8,
    parameter     RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_halt_req,
    input  logic        i_resume,
    output logic        o_halted,
    output logic [31:0] o_pc,
    output logic        o_busy,
    output logic        o_timeout,
    output logic        o_abort,
    output logic        o_debug_interrupt,
    input  logic        i_debug,
    input  logic        i_debug_we,
    input  logic        i_debug_dat
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_HALTED  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [TIMEOUT_W-1:0] TMO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    // Last REQ cycle before the counter would reach all-ones.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam bit RST_DATA = (RESET_STRATEGY != "NONE");

    logic [2:0]           state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [31:0]          shreg_q;
    logic [31:0]          pc_q;
    logic                 shift_s, load_s;
    logic                 timeout_d, abort_d;
    logic                 dbg_int_q, halted_q, busy_q, timeout_q, abort_q;

    // Next-state, counter and pulse decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        shift_s   = 1'b0;
        load_s    = 1'b0;
        timeout_d = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_halt_req) begin
                    state_d = S_REQ;
                    cnt_d   = 5'd0;
                    tmo_d   = {TIMEOUT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + TMO_ONE;
                // A strobe on the final cycle beats the timeout.
                if (i_debug_we) begin
                    shift_s = 1'b1;
                    cnt_d   = 5'd1;
                    state_d = S_CAPTURE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_CAPTURE: begin
                if (i_debug_we) begin
                    shift_s = 1'b1;
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        load_s  = 1'b1;
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end else if (!i_debug) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_HALTED: begin
                if (i_resume) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_HALTED;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Control state and registered status outputs, decoded from next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            tmo_q     <= {TIMEOUT_W{1'b0}};
            dbg_int_q <= 1'b0;
            halted_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            dbg_int_q <= (state_d == S_REQ) || (state_d == S_HALTED);
            halted_q  <= (state_d == S_HALTED);
            busy_q    <= (state_d == S_REQ) || (state_d == S_CAPTURE);
            timeout_q <= timeout_d;
            abort_q   <= abort_d;
        end
    end

    // Serial PC shift register and captured PC.
    always_ff @(posedge i_clk) begin
        if (i_rst && RST_DATA) begin
            shreg_q <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            if (shift_s && !i_rst) begin
                shreg_q <= {i_debug_dat, shreg_q[31:1]};
            end
            if (load_s && !i_rst) begin
                pc_q <= {i_debug_dat, shreg_q[31:1]};
            end
        end
    end

    assign o_halted          = halted_q;
    assign o_pc              = pc_q;
    assign o_busy            = busy_q;
    assign o_timeout         = timeout_q;
    assign o_abort           = abort_q;
    assign o_debug_interrupt = dbg_int_q;

endmodule

// File: tb/tb_serv_debug_host.sv
// Randomized scoreboard bench for serv_debug_host: expected halt/timeout/abort
// events are queued by the stimulus and matched by an output monitor.
module tb_serv_debug_host;

    localparam int EV_HALT  = 0;
    localparam int EV_TMO   = 1;
    localparam int EV_ABORT = 2;
    localparam int TMO_CYC  = 15;  // 2^4 - 1 with TIMEOUT_W = 4

    typedef struct {
        int          kind;
        logic [31:0] pc;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        i_rst, i_halt_req, i_resume, i_debug, i_debug_we, i_debug_dat;
    logic        o_halted, o_busy, o_timeout, o_abort, o_debug_interrupt;
    logic [31:0] o_pc;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    logic [31:0] held_pc;
    logic halted_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    serv_debug_host #(.TIMEOUT_W(4), .RESET_STRATEGY("MINI")) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_halt_req(i_halt_req), .i_resume(i_resume),
        .o_halted(o_halted), .o_pc(o_pc), .o_busy(o_busy), .o_timeout(o_timeout),
        .o_abort(o_abort), .o_debug_interrupt(o_debug_interrupt),
        .i_debug(i_debug), .i_debug_we(i_debug_we), .i_debug_dat(i_debug_dat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [31:0] pc, input int at);
        ev_t e;
        e.kind = kind;
        e.pc   = pc;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: match every observed event against the scoreboard queue.
    task automatic got(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_pc", o_pc, e.pc);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (o_timeout && o_abort) chk("timeout_abort_exclusive", 32'd1, 32'd0);
        if (o_halted && !halted_prev) got(EV_HALT);
        if (o_timeout) got(EV_TMO);
        if (o_abort) got(EV_ABORT);
        halted_prev = o_halted;
    end

    task automatic clear_inputs();
        i_halt_req  = 1'b0;
        i_resume    = 1'b0;
        i_debug_we  = 1'b0;
        i_debug_dat = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_debug = 1'b0;
        i_rst   = 1'b1;
        tick();
        tick();
        chk("rst_debug_interrupt", o_debug_interrupt, 1'b0);
        chk("rst_halted", o_halted, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_timeout", o_timeout, 1'b0);
        chk("rst_abort", o_abort, 1'b0);
        chk("rst_pc", o_pc, 32'd0);
        held_pc = 32'd0;
        i_rst   = 1'b0;
        tick();
    endtask

    task automatic halt_pulse();
        chk("idle_irq_low", o_debug_interrupt, 1'b0);
        i_halt_req = 1'b1;
        tick();
        i_halt_req = 1'b0;
        chk("req_irq_high", o_debug_interrupt, 1'b1);
        chk("req_busy", o_busy, 1'b1);
    endtask

    // Core side: after d idle REQ cycles, stream n bits of v with optional gaps.
    task automatic send_bits(input logic [31:0] v, input int d, input int n, input logic [31:0] gaps);
        for (int i = 0; i < d; i++) tick();
        i_debug = 1'b1;
        for (int b = 0; b < n; b++) begin
            i_debug_we  = 1'b1;
            i_debug_dat = v[b];
            if (n == 32 && b == 31) push_ev(EV_HALT, v, cyc + 1);
            tick();
            i_debug_we  = 1'b0;
            i_debug_dat = 1'b0;
            if (gaps[b] && b < n - 1) tick();
        end
    endtask

    task automatic capture(input logic [31:0] v, input int d, input logic [31:0] gaps);
        halt_pulse();
        send_bits(v, d, 32, gaps);
        held_pc = v;
        chk("halted_busy_low", o_busy, 1'b0);
        chk("halted_irq_high", o_debug_interrupt, 1'b1);
        for (int i = 0; i < 3; i++) begin
            i_debug_we  = 1'b1;
            i_debug_dat = 1'($urandom);
            tick();
        end
        i_debug_we = 1'b0;
        chk("halted_pc_held", o_pc, held_pc);
        chk("halted_level", o_halted, 1'b1);
    endtask

    task automatic resume(input bit with_halt);
        i_resume   = 1'b1;
        i_halt_req = with_halt;
        tick();
        clear_inputs();
        i_debug = 1'b0;
        chk("release_halted_low", o_halted, 1'b0);
        chk("release_irq_low", o_debug_interrupt, 1'b0);
        tick();
        chk("post_release_irq_low", o_debug_interrupt, 1'b0);
        chk("post_release_busy", o_busy, 1'b0);
    endtask

    task automatic timeout_run();
        halt_pulse();
        push_ev(EV_TMO, held_pc, cyc + TMO_CYC - 1 + 1);
        for (int i = 0; i < TMO_CYC; i++) tick();
        chk("timeout_irq_low", o_debug_interrupt, 1'b0);
        chk("timeout_busy_low", o_busy, 1'b0);
        tick();
    endtask

    task automatic abort_run(input logic [31:0] v, input int n);
        halt_pulse();
        send_bits(v, 0, n, 32'd0);
        i_debug = 1'b0;
        push_ev(EV_ABORT, held_pc, cyc + 1);
        tick();
        chk("abort_busy_low", o_busy, 1'b0);
        chk("abort_irq_low", o_debug_interrupt, 1'b0);
        chk("abort_pc_held", o_pc, held_pc);
        tick();
    endtask

    initial begin
        logic [31:0] v;
        int op;
        clear_inputs();
        i_debug = 1'b0;
        i_rst   = 1'b1;
        held_pc = 32'd0;
        do_reset();

        capture(32'h8000_1234, 0, 32'd0);
        resume(1'b1);
        capture(32'hDEAD_BEEF, 2, (32'd1 << 3) | (32'd1 << 17) | (32'd1 << 30));
        resume(1'b0);
        timeout_run();
        capture(32'h0F0F_A5A5, TMO_CYC - 1, 32'd0);
        resume(1'b1);
        abort_run(32'h1234_5678, 10);

        // Reset mid-capture, then a clean capture.
        halt_pulse();
        send_bits(32'hCAFE_F00D, 1, 16, 32'd0);
        do_reset();
        capture(32'h7654_3210, 3, 32'd0);
        resume(1'b0);

        for (int it = 0; it < 25; it++) begin
            v  = $urandom;
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                capture(v, $urandom_range(0, TMO_CYC - 1), $urandom & $urandom & $urandom);
                resume(1'($urandom));
            end else if (op <= 7) begin
                abort_run(v, $urandom_range(1, 31));
            end else if (op == 8) begin
                timeout_run();
            end else begin
                halt_pulse();
                send_bits(v, 0, $urandom_range(1, 31), 32'd0);
                do_reset();
            end
        end

        for (int i = 0; i < 4; i++) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
